exp_adjust_pipe: RTL and testbench

Parametrised, pipelined exponent-correction unit for the IEEE-754 multiplier datapath. It generalises the 8-bit carry-correct adder in three ways:
- it sums two biased exponents, removes the bias and adds the mantissa normalisation carry;
- it classifies the result (normal / overflow / underflow / zero / special);
- it presents the result over a valid/ready handshake with full throughput and backpressure.

It sits between the operand-unpack stage and the result-pack stage, in parallel with the mantissa multiplier.

---
 rtl/fp_mul_pkg.sv | 32 +++
 rtl/exp_classify.sv | 54 +++++
 rtl/exp_adjust_pipe.sv | 116 +++++++++++
 tb/tb_exp_adjust_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants and the exponent class encoding for the FP multiplier datapath.
// The pack stage decodes exp_class_e, so the encoding is fixed here once.
package fp_mul_pkg;

    localparam int EXP_W_SP = 8;
    localparam int EXP_W_DP = 11;
    localparam int BIAS_SP  = (2 ** (EXP_W_SP - 1)) - 1;
    localparam int BIAS_DP  = (2 ** (EXP_W_DP - 1)) - 1;

    typedef enum logic [2:0] {
        EXP_NORMAL  = 3'd0,
        EXP_OVF     = 3'd1,
        EXP_UNF     = 3'd2,
        EXP_ZERO    = 3'd3,
        EXP_SPECIAL = 3'd4
    } exp_class_e;

    // Flag vector {ovf, unf, zero, special} for a given class.
    function automatic logic [3:0] class_flags(input exp_class_e cls);
        logic [3:0] flags;
        flags = 4'b0000;
        case (cls)
            EXP_OVF:     flags = 4'b1000;
            EXP_UNF:     flags = 4'b0100;
            EXP_ZERO:    flags = 4'b0010;
            EXP_SPECIAL: flags = 4'b0001;
            default:     flags = 4'b0000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/exp_classify.sv
// Combinational second-stage arithmetic: removes the bias, adds the
// normalisation carry, and classifies the corrected exponent with a fixed
// priority (special > zero > overflow > underflow > normal).
module exp_classify
    import fp_mul_pkg::*;
#(
    parameter int EXP_W    = EXP_W_SP,
    parameter int BIAS     = (2 ** (EXP_W - 1)) - 1,
    parameter bit SATURATE = 1'b1
) (
    input  logic [EXP_W:0]   sum,
    input  logic             carry,
    input  logic             any_zero,
    input  logic             any_special,
    output logic [EXP_W-1:0] exp_res,
    output exp_class_e       cls
);

    // Two extra bits: one for the sum carry-out, one for the sign after
    // subtracting the bias.
    localparam logic [EXP_W+1:0] BIAS_W = (EXP_W + 2)'(BIAS);
    localparam logic [EXP_W+1:0] OVF_TH = (EXP_W + 2)'((2 ** EXP_W) - 1);

    logic [EXP_W+1:0] e_wide;
    logic             e_neg;
    logic             e_ovf;
    logic             e_unf;

    assign e_wide = {1'b0, sum} + {{(EXP_W + 1){1'b0}}, carry} - BIAS_W;
    assign e_neg  = e_wide[EXP_W+1];
    // Once non-negative the value is compared unsigned against the threshold.
    assign e_ovf  = !e_neg && (e_wide >= OVF_TH);
    assign e_unf  = e_neg || (e_wide == '0);

    // Priority classifier; wrap mode keeps the low EXP_W bits of the true result.
    always_comb begin
        exp_res = e_wide[EXP_W-1:0];
        cls     = EXP_NORMAL;
        if (any_special) begin
            exp_res = '1;
            cls     = EXP_SPECIAL;
        end else if (any_zero) begin
            exp_res = '0;
            cls     = EXP_ZERO;
        end else if (e_ovf) begin
            exp_res = SATURATE ? '1 : e_wide[EXP_W-1:0];
            cls     = EXP_OVF;
        end else if (e_unf) begin
            exp_res = SATURATE ? '0 : e_wide[EXP_W-1:0];
            cls     = EXP_UNF;
        end
    end

endmodule

// File: rtl/exp_adjust_pipe.sv
// Two-stage exponent correction pipe with valid/ready handshake.
// S1 registers the raw exponent sum and operand detects; S2 registers the
// classified result. A single global advance enable stalls both stages.
module exp_adjust_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W    = EXP_W_SP,
    parameter int BIAS     = (2 ** (EXP_W - 1)) - 1,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             norm_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             ovf,
    output logic             unf,
    output logic             zero,
    output logic             special
);

    logic             adv;
    logic [EXP_W-1:0] in_ops [2];
    logic [1:0]       op_zero;
    logic [1:0]       op_ones;
    logic [EXP_W:0]   sum_next;

    logic             s1_valid_reg;
    logic [EXP_W:0]   s1_sum_reg;
    logic             s1_carry_reg;
    logic [1:0]       s1_zero_reg;
    logic [1:0]       s1_ones_reg;

    logic [EXP_W-1:0] exp_next;
    exp_class_e       cls_next;
    logic [3:0]       flags_next;

    logic             out_valid_reg;
    logic [EXP_W-1:0] exp_out_reg;
    logic [3:0]       flags_reg;

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv && !rst;

    assign in_ops[0] = exp_a;
    assign in_ops[1] = exp_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op_detect
            assign op_zero[gi] = (in_ops[gi] == '0);
            assign op_ones[gi] = &in_ops[gi];
        end
    endgenerate

    assign sum_next = {1'b0, exp_a} + {1'b0, exp_b};

    exp_classify #(
        .EXP_W    (EXP_W),
        .BIAS     (BIAS),
        .SATURATE (SATURATE)
    ) u_classify (
        .sum         (s1_sum_reg),
        .carry       (s1_carry_reg),
        .any_zero    (|s1_zero_reg),
        .any_special (|s1_ones_reg),
        .exp_res     (exp_next),
        .cls         (cls_next)
    );

    assign flags_next = class_flags(cls_next);

    // Stage 1: capture the operand sum and detects; bubbles load as invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            s1_carry_reg <= 1'b0;
            s1_zero_reg  <= '0;
            s1_ones_reg  <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_sum_reg   <= sum_next;
            s1_carry_reg <= norm_carry;
            s1_zero_reg  <= op_zero;
            s1_ones_reg  <= op_ones;
        end
    end

    // Stage 2: register the classified result; held unchanged while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            exp_out_reg   <= '0;
            flags_reg     <= '0;
        end else if (adv) begin
            out_valid_reg <= s1_valid_reg;
            exp_out_reg   <= exp_next;
            flags_reg     <= flags_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign exp_out   = exp_out_reg;
    assign ovf       = flags_reg[3];
    assign unf       = flags_reg[2];
    assign zero      = flags_reg[1];
    assign special   = flags_reg[0];

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Directed bench for exp_adjust_pipe: a saturating and a wrapping instance
// share stimulus; each feature task checks its own expected values.
module tb_exp_adjust_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;
    logic       norm_carry = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, in_ready_w;
    logic       out_valid_s, out_valid_w;
    logic [7:0] exp_out_s, exp_out_w;
    logic       ovf_s, unf_s, zero_s, special_s;
    logic       ovf_w, unf_w, zero_w, special_w;
    logic [3:0] flags_s, flags_w;

    int n_cmp  = 0;
    int n_fail = 0;

    assign flags_s = {ovf_s, unf_s, zero_s, special_s};
    assign flags_w = {ovf_w, unf_w, zero_w, special_w};

    always #5 clk = ~clk;

    exp_adjust_pipe #(.EXP_W(8), .BIAS(127), .SATURATE(1'b1)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .norm_carry (norm_carry),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .exp_out    (exp_out_s),
        .ovf        (ovf_s),
        .unf        (unf_s),
        .zero       (zero_s),
        .special    (special_s)
    );

    exp_adjust_pipe #(.EXP_W(8), .BIAS(127), .SATURATE(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .norm_carry (norm_carry),
        .out_valid  (out_valid_w),
        .out_ready  (out_ready),
        .exp_out    (exp_out_w),
        .ovf        (ovf_w),
        .unf        (unf_w),
        .zero       (zero_w),
        .special    (special_w)
    );

    // Directed vectors (BIAS = 127). Flags are {ovf, unf, zero, special}.
    //   rows 0-3 normal, 4-6 overflow, 7-8 underflow, 9-12 special/zero priority
    logic [7:0] va    [13] = '{8'h80, 8'hFE, 8'h7F, 8'h7E, 8'hFE, 8'hFE, 8'hFE,
                               8'h01, 8'h7E, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0] vb    [13] = '{8'h7F, 8'h7F, 8'h01, 8'h01, 8'hFE, 8'h80, 8'h7F,
                               8'h01, 8'h01, 8'h00, 8'h90, 8'hFF, 8'hFF};
    logic       vc    [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] vsat  [13] = '{8'h81, 8'hFE, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF,
                               8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] vwrap [13] = '{8'h81, 8'hFE, 8'h01, 8'h01, 8'h7D, 8'hFF, 8'hFF,
                               8'h83, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    logic [3:0] vflg  [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000,
                               4'b0100, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 4'b0001};

    // Drives one beat and returns at the negedge after the second edge following acceptance.
    task automatic issue_beat(input logic [7:0] a, input logic [7:0] b, input logic c,
                              output logic rdy, output logic early_v);
        @(posedge clk); #1;
        exp_a = a; exp_b = b; norm_carry = c; in_valid = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        early_v = out_valid_s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b/%b want 0/0", out_valid_s, out_valid_w);
        end
        n_cmp++;
        if (exp_out_s !== 8'h00 || exp_out_w !== 8'h00) begin
            n_fail++; $display("FAIL reset_exp_out: got %h/%h want 00/00", exp_out_s, exp_out_w);
        end
        n_cmp++;
        if (flags_s !== 4'b0000 || flags_w !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b/%b want 0000/0000", flags_s, flags_w);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        $display("txn reset: outputs cleared, in_ready=%b after release", in_ready);
    endtask

    task automatic test_arith(input string tag, input int lo, input int hi);
        logic rdy, early_v;
        for (int i = lo; i <= hi; i++) begin
            issue_beat(va[i], vb[i], vc[i], rdy, early_v);
            $display("txn %s a=%h b=%h c=%b -> sat=%h wrap=%h flags=%b/%b",
                     tag, va[i], vb[i], vc[i], exp_out_s, exp_out_w, flags_s, flags_w);
            n_cmp++;
            if (rdy !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready row %0d: got %b want 1", tag, i, rdy); end
            n_cmp++;
            if (early_v !== 1'b0) begin n_fail++; $display("FAIL %s_latency row %0d: out_valid after 1 edge got %b want 0", tag, i, early_v); end
            n_cmp++;
            if (out_valid_s !== 1'b1 || out_valid_w !== 1'b1) begin
                n_fail++; $display("FAIL %s_out_valid row %0d: got %b/%b want 1/1", tag, i, out_valid_s, out_valid_w);
            end
            n_cmp++;
            if (exp_out_s !== vsat[i]) begin n_fail++; $display("FAIL %s_exp_sat row %0d: got %h want %h", tag, i, exp_out_s, vsat[i]); end
            n_cmp++;
            if (exp_out_w !== vwrap[i]) begin n_fail++; $display("FAIL %s_exp_wrap row %0d: got %h want %h", tag, i, exp_out_w, vwrap[i]); end
            n_cmp++;
            if (flags_s !== vflg[i]) begin n_fail++; $display("FAIL %s_flags_sat row %0d: got %b want %b", tag, i, flags_s, vflg[i]); end
            n_cmp++;
            if (flags_w !== vflg[i]) begin n_fail++; $display("FAIL %s_flags_wrap row %0d: got %b want %b", tag, i, flags_w, vflg[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        int stall_cycles = 0;
        logic stall_prev = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] want;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid   = (sent < 6);
            exp_a      = 8'(128 + sent);
            exp_b      = 8'h7F;
            norm_carry = 1'b0;
            out_ready  = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (stall_prev) begin
                n_cmp++;
                if (out_valid_s !== 1'b1 || exp_out_s !== held) begin
                    n_fail++; $display("FAIL bp_hold cyc %0d: got valid=%b exp=%h want valid=1 exp=%h", cyc, out_valid_s, exp_out_s, held);
                end
            end
            if (out_valid_s && !out_ready) begin
                stall_cycles++;
                n_cmp++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b want 0", cyc, in_ready); end
            end
            if (out_valid_s && out_ready) begin
                n_cmp++;
                if (recv >= 6) begin
                    n_fail++; $display("FAIL bp_extra cyc %0d: got result %h want none", cyc, exp_out_s);
                end else begin
                    want = 8'(128 + recv);
                    $display("txn stream #%0d -> exp=%h flags=%b", recv, exp_out_s, flags_s);
                    if (exp_out_s !== want || flags_s !== 4'b0000) begin
                        n_fail++; $display("FAIL bp_order #%0d: got %h/%b want %h/0000", recv, exp_out_s, flags_s, want);
                    end
                    recv++;
                end
            end
            stall_prev = out_valid_s && !out_ready;
            held = exp_out_s;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (recv != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", recv); end
        n_cmp++;
        if (stall_cycles != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_cycles); end
    endtask

    task automatic test_reset_flush();
        logic rdy, early_v;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_a = 8'h80; exp_b = 8'h7F; norm_carry = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_a = 8'hFE; exp_b = 8'h7F; norm_carry = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid_s !== 1'b1 || exp_out_s !== 8'h81) begin
            n_fail++; $display("FAIL flush_pre: got valid=%b exp=%h want 1/81", out_valid_s, exp_out_s);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid_s !== 1'b0 || exp_out_s !== 8'h00 || flags_s !== 4'b0000) begin
            n_fail++; $display("FAIL flush_clear: got valid=%b exp=%h flags=%b want 0/00/0000", out_valid_s, exp_out_s, flags_s);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin
                n_fail++; $display("FAIL flush_ghost cyc %0d: got %b/%b want 0/0", k, out_valid_s, out_valid_w);
            end
        end
        issue_beat(8'h7F, 8'h01, 1'b0, rdy, early_v);
        $display("txn post-reset a=7f b=01 -> exp=%h valid=%b", exp_out_s, out_valid_s);
        n_cmp++;
        if (early_v !== 1'b0) begin n_fail++; $display("FAIL flush_new_latency: got %b want 0", early_v); end
        n_cmp++;
        if (out_valid_s !== 1'b1 || exp_out_s !== 8'h01) begin
            n_fail++; $display("FAIL flush_new_beat: got valid=%b exp=%h want 1/01", out_valid_s, exp_out_s);
        end
    endtask

    initial begin
        test_reset();
        test_arith("normal", 0, 3);
        test_arith("overflow", 4, 6);
        test_arith("underflow", 7, 8);
        test_arith("priority", 9, 12);
        test_back_to_back();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
